// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column sweep, debounced press/release FSM,
// and a four-digit history of accepted keys for a seven-segment driver.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 100000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Clear,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] SSD3,
  output logic [3:0] SSD2,
  output logic [3:0] SSD1,
  output logic [3:0] SSD0
);

  localparam int MAXC = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] REL_LAST  = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  logic [3:0]    sync1_r;
  logic [3:0]    rs_r;
  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]    col_idx_r;
  logic [1:0]    row_idx_r;
  logic [3:0]    col_r;
  logic [3:0]    code_r;
  logic          valid_r;
  logic          held_r;
  logic [3:0]    ssd3_r;
  logic [3:0]    ssd2_r;
  logic [3:0]    ssd1_r;
  logic [3:0]    ssd0_r;

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    col_drive = 4'b1110;
      2'd1:    col_drive = 4'b1101;
      2'd2:    col_drive = 4'b1011;
      2'd3:    col_drive = 4'b0111;
      default: col_drive = 4'b1110;
    endcase
  endfunction

  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    if (!rows[0]) begin
      lowest_low = 2'd0;
    end else if (!rows[1]) begin
      lowest_low = 2'd1;
    end else if (!rows[2]) begin
      lowest_low = 2'd2;
    end else begin
      lowest_low = 2'd3;
    end
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'b00_00: key_map = 4'h1;
      4'b00_01: key_map = 4'h2;
      4'b00_10: key_map = 4'h3;
      4'b00_11: key_map = 4'hA;
      4'b01_00: key_map = 4'h4;
      4'b01_01: key_map = 4'h5;
      4'b01_10: key_map = 4'h6;
      4'b01_11: key_map = 4'hB;
      4'b10_00: key_map = 4'h7;
      4'b10_01: key_map = 4'h8;
      4'b10_10: key_map = 4'h9;
      4'b10_11: key_map = 4'hC;
      4'b11_00: key_map = 4'h0;
      4'b11_01: key_map = 4'hF;
      4'b11_10: key_map = 4'hE;
      4'b11_11: key_map = 4'hD;
      default:  key_map = 4'h0;
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous row lines (idle = released).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_r <= 4'b1111;
      rs_r    <= 4'b1111;
    end else begin
      sync1_r <= ROW;
      rs_r    <= sync1_r;
    end
  end

  // Scan / debounce FSM with all outputs and the digit history registered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= SCAN;
      cnt_r     <= '0;
      col_idx_r <= 2'd0;
      row_idx_r <= 2'd0;
      col_r     <= 4'b1110;
      code_r    <= 4'h0;
      valid_r   <= 1'b0;
      held_r    <= 1'b0;
      ssd3_r    <= 4'h0;
      ssd2_r    <= 4'h0;
      ssd1_r    <= 4'h0;
      ssd0_r    <= 4'h0;
    end else begin
      valid_r <= 1'b0;
      if (Clear) begin
        ssd3_r <= 4'h0;
        ssd2_r <= 4'h0;
        ssd1_r <= 4'h0;
        ssd0_r <= 4'h0;
      end else begin
        ssd0_r <= ssd0_r;
      end

      case (state_r)
        SCAN: begin
          if (cnt_r == SCAN_LAST) begin
            cnt_r <= '0;
            if (rs_r == 4'b1111) begin
              col_idx_r <= col_idx_r + 2'd1;
              col_r     <= col_drive(col_idx_r + 2'd1);
            end else begin
              row_idx_r <= lowest_low(rs_r);
              state_r   <= DEBOUNCE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        DEBOUNCE: begin
          if (cnt_r == DEB_LAST) begin
            valid_r <= 1'b1;
            held_r  <= 1'b1;
            code_r  <= key_map(row_idx_r, col_idx_r);
            state_r <= HELD;
            cnt_r   <= '0;
            // A coincident Clear wipes the older digits but keeps the new one.
            if (Clear) begin
              ssd3_r <= 4'h0;
              ssd2_r <= 4'h0;
              ssd1_r <= 4'h0;
            end else begin
              ssd3_r <= ssd2_r;
              ssd2_r <= ssd1_r;
              ssd1_r <= ssd0_r;
            end
            ssd0_r <= key_map(row_idx_r, col_idx_r);
          end else if (rs_r[row_idx_r]) begin
            state_r   <= SCAN;
            cnt_r     <= '0;
            col_idx_r <= col_idx_r + 2'd1;
            col_r     <= col_drive(col_idx_r + 2'd1);
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        HELD: begin
          if (rs_r[row_idx_r]) begin
            state_r <= RELEASE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= '0;
          end
        end

        RELEASE: begin
          if (!rs_r[row_idx_r]) begin
            state_r <= HELD;
            cnt_r   <= '0;
          end else if (cnt_r == REL_LAST) begin
            held_r    <= 1'b0;
            state_r   <= SCAN;
            cnt_r     <= '0;
            col_idx_r <= col_idx_r + 2'd1;
            col_r     <= col_drive(col_idx_r + 2'd1);
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        default: begin
          state_r <= SCAN;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign COL       = col_r;
  assign key_code  = code_r;
  assign key_valid = valid_r;
  assign key_held  = held_r;
  assign SSD3      = ssd3_r;
  assign SSD2      = ssd2_r;
  assign SSD1      = ssd1_r;
  assign SSD0      = ssd0_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model drives ROW from COL,
// a vector table covers the idle sweep, hand sequences cover press corners.
module tb_keypad_scanner;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Clear;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] SSD3, SSD2, SSD1, SSD0;

  logic [15:0] pressed;   // bit row*4+col is a closed switch
  int          tests = 0;
  int          fails = 0;
  int          valid_cnt = 0;
  logic [3:0]  last_code = 4'h0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  exp_col;
    logic        exp_valid;
    logic        exp_held;
  } vec_t;

  vec_t vecs[20];

  always #5 Clk = ~Clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .ROW(ROW), .COL(COL),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .SSD3(SSD3), .SSD2(SSD2), .SSD1(SSD1), .SSD0(SSD0)
  );

  // A row line is pulled low through any closed switch whose column is driven low.
  always_comb begin
    ROW = 4'hF;
    for (int r = 0; r < 4; r++) ROW[r] = ~|(pressed[r*4 +: 4] & ~COL);
  end

  always @(negedge Clk) begin
    if (key_valid) begin
      valid_cnt <= valid_cnt + 1;
      last_code <= key_code;
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_col_start(input logic [3:0] pat);
    int n = 0;
    while (COL == pat && n < 40) begin tick(); n++; end
    while (COL != pat && n < 40) begin tick(); n++; end
    check("col_reach", 16'(COL), 16'(pat));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (key_held && n < 60) begin tick(); n++; end
    check(name, 16'(key_held), 16'h0);
    repeat (4) tick();
  endtask

  task automatic press_key(input int r, input int c, input int hold);
    pressed[r*4 + c] = 1'b1;
    repeat (hold) tick();
    pressed[r*4 + c] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] sweep[4];
    int         vc;
    logic       found;

    sweep[0] = 4'b1110; sweep[1] = 4'b1101; sweep[2] = 4'b1011; sweep[3] = 4'b0111;
    for (int k = 0; k < 20; k++) vecs[k] = '{16'h0000, sweep[(k / 4) % 4], 1'b0, 1'b0};

    Reset = 1'b1; Clear = 1'b0; pressed = 16'h0000;
    repeat (3) tick();
    Reset = 1'b0;

    check("reset_code", 16'(key_code), 16'h0);
    check("reset_ssd", {SSD3, SSD2, SSD1, SSD0}, 16'h0000);

    // Idle sweep: each column low for four cycles, never a key_valid.
    for (int k = 0; k < 20; k++) begin
      pressed = vecs[k].keys;
      check($sformatf("sweep_col[%0d]", k), 16'(COL), 16'(vecs[k].exp_col));
      check($sformatf("sweep_valid[%0d]", k), 16'(key_valid), 16'(vecs[k].exp_valid));
      check($sformatf("sweep_held[%0d]", k), 16'(key_held), 16'(vecs[k].exp_held));
      tick();
    end

    // Single press of 6 (row1/col2) held 40 cycles.
    vc = valid_cnt;
    pressed[1*4 + 2] = 1'b1;
    repeat (40) tick();
    check("press6_count", 16'(valid_cnt - vc), 16'd1);
    check("press6_code", 16'(key_code), 16'h6);
    check("press6_ssd0", 16'(SSD0), 16'h6);
    check("press6_held", 16'(key_held), 16'h1);
    pressed = 16'h0000;
    repeat (8) tick();
    check("press6_held_after_release", 16'(key_held), 16'h1);
    wait_idle("press6_release");
    check("press6_once", 16'(valid_cnt - vc), 16'd1);

    // Bounce on key 1: 5 low, 1 high, then low until accepted.
    wait_col_start(4'b1110);
    vc = valid_cnt;
    pressed[0] = 1'b1;
    repeat (5) tick();
    pressed[0] = 1'b0;
    tick();
    pressed[0] = 1'b1;
    repeat (8) tick();
    check("bounce_early", 16'(valid_cnt - vc), 16'd0);
    repeat (50) tick();
    check("bounce_count", 16'(valid_cnt - vc), 16'd1);
    check("bounce_code", 16'(last_code), 16'h1);
    pressed = 16'h0000;
    wait_idle("bounce_release");

    // History: 1, 2, 3, A.
    for (int c = 0; c < 4; c++) begin
      press_key(0, c, 40);
      wait_idle($sformatf("hist_release[%0d]", c));
    end
    check("hist_ssd", {SSD3, SSD2, SSD1, SSD0}, 16'h123A);
    check("hist_code", 16'(key_code), 16'hA);

    // Clear held across the accept of 5.
    pressed[1*4 + 1] = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      Clear = 1'b1;
      tick();
      if (key_valid) found = 1'b1;
    end
    Clear = 1'b0;
    check("clear_accept_seen", 16'(found), 16'h1);
    check("clear_accept_ssd", {SSD3, SSD2, SSD1, SSD0}, 16'h0005);
    check("clear_accept_code", 16'(key_code), 16'h5);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("clear_only_ssd", {SSD3, SSD2, SSD1, SSD0}, 16'h0000);
    check("clear_only_code", 16'(key_code), 16'h5);
    check("clear_only_held", 16'(key_held), 16'h1);
    pressed = 16'h0000;
    wait_idle("clear_release");

    // D and 0 together, pressed just after the wrap to col0.
    wait_col_start(4'b0111);
    wait_col_start(4'b1110);
    vc = valid_cnt;
    pressed[3*4 + 0] = 1'b1;
    pressed[3*4 + 3] = 1'b1;
    repeat (40) tick();
    check("multi_count", 16'(valid_cnt - vc), 16'd1);
    check("multi_first", 16'(last_code), 16'h0);
    check("multi_held", 16'(key_held), 16'h1);
    pressed[3*4 + 0] = 1'b0;
    repeat (60) tick();
    check("multi_second_count", 16'(valid_cnt - vc), 16'd2);
    check("multi_second_code", 16'(key_code), 16'hD);
    check("multi_second_ssd", {8'h00, SSD1, SSD0}, 16'h000D);
    pressed = 16'h0000;
    wait_idle("multi_release");

    // Reset while debouncing key 9.
    wait_col_start(4'b1011);
    pressed[2*4 + 2] = 1'b1;
    repeat (5) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    pressed = 16'h0000;
    check("rst_col", 16'(COL), 16'(4'b1110));
    check("rst_valid", 16'(key_valid), 16'h0);
    check("rst_held", 16'(key_held), 16'h0);
    check("rst_code", 16'(key_code), 16'h0);
    check("rst_ssd", {SSD3, SSD2, SSD1, SSD0}, 16'h0000);
    vc = valid_cnt;
    repeat (30) tick();
    check("rst_no_accept", 16'(valid_cnt - vc), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
